uart_cmd_deframer: RTL



---
 rtl/uart_cmd_deframer_pkg.sv | 26 ++
 rtl/uart_cmd_deframer_payload_buf.sv | 26 ++
 rtl/uart_cmd_deframer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_deframer_pkg.sv
// Shared frame-format constants, parser state encoding and checksum helper
// for the UART command deframer.
package uart_cmd_deframer_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // ADDR byte layout: {addr[6:0], rw}
    localparam int ADDR_MSB    = 7;
    localparam int ADDR_LSB    = 1;
    localparam int ADDR_RW_BIT = 0;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_ISSUE   = 3'd5,
        ST_STREAM  = 3'd6
    } deframe_state_e;

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_cmd_deframer_payload_buf.sv
// Write-payload holding buffer: simple dual-port RAM, synchronous write,
// combinational read, so STREAM can present the next byte without a bubble.
module uart_cmd_deframer_payload_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];

    // Payload capture port; contents are only consumed after a full checked frame
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/uart_cmd_deframer.sv
// Deframes host command packets from a FWFT UART RX FIFO into checked I2C
// descriptors and a buffered write-payload stream.
module uart_cmd_deframer
    import uart_cmd_deframer_pkg::*;
#(
    parameter int         DATA_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_avail,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_rd,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [6:0]            cmd_addr,
    output logic                  cmd_rw,
    output logic [7:0]            cmd_len,
    output logic                  wdata_valid,
    input  logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_last,
    output logic                  frame_err,
    output logic [7:0]            err_count
);

    localparam int             AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    deframe_state_e state_r, state_nxt;

    logic [6:0]    addr_r;
    logic          rw_r;
    logic [7:0]    len_r;
    logic [7:0]    chk_r;
    logic [7:0]    cnt_r;
    logic [7:0]    rd_ptr_r;
    logic [TW-1:0] to_cnt_r;
    logic          cmd_valid_r;
    logic          wdata_valid_r;
    logic [7:0]    wdata_r;
    logic          wdata_last_r;
    logic          frame_err_r;
    logic [7:0]    err_count_r;

    logic          rx_rd_s;
    logic          err_s;
    logic          timeout_s;
    logic          in_frame_s;
    logic          buf_we_s;
    logic [7:0]    buf_rdata_s;

    assign in_frame_s = (state_r == ST_ADDR) || (state_r == ST_LEN) ||
                        (state_r == ST_PAYLOAD) || (state_r == ST_CHK);
    assign timeout_s  = (to_cnt_r == TO_LAST);
    assign buf_we_s   = (state_r == ST_PAYLOAD) && rx_rd_s;

    uart_cmd_deframer_payload_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_payload_buf (
        .clk   (clk),
        .we    (buf_we_s),
        .waddr (cnt_r[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_r[AW-1:0]),
        .rdata (buf_rdata_s)
    );

    // Parser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state, pop strobe and discard decision; a frame state with an empty FIFO may time out
    always_comb begin
        state_nxt = state_r;
        rx_rd_s   = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_HUNT: begin
                rx_rd_s = rx_avail;
                if (rx_avail && (rx_data == SYNC_BYTE)) state_nxt = ST_ADDR;
                else                                    state_nxt = ST_HUNT;
            end
            ST_ADDR: begin
                rx_rd_s = rx_avail;
                if (rx_avail)       state_nxt = ST_LEN;
                else if (timeout_s) begin state_nxt = ST_HUNT; err_s = 1'b1; end
                else                state_nxt = ST_ADDR;
            end
            ST_LEN: begin
                rx_rd_s = rx_avail;
                if (rx_avail) begin
                    if (!rw_r && (rx_data > MAX_LEN_B))       begin state_nxt = ST_HUNT; err_s = 1'b1; end
                    else if (!rw_r && (rx_data != 8'd0))      state_nxt = ST_PAYLOAD;
                    else                                      state_nxt = ST_CHK;
                end else if (timeout_s) begin
                    state_nxt = ST_HUNT;
                    err_s     = 1'b1;
                end else begin
                    state_nxt = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                rx_rd_s = rx_avail;
                if (rx_avail) begin
                    if (cnt_r == (len_r - 8'd1)) state_nxt = ST_CHK;
                    else                         state_nxt = ST_PAYLOAD;
                end else if (timeout_s) begin
                    state_nxt = ST_HUNT;
                    err_s     = 1'b1;
                end else begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                rx_rd_s = rx_avail;
                if (rx_avail) begin
                    if (rx_data == chk_r) state_nxt = ST_ISSUE;
                    else                  begin state_nxt = ST_HUNT; err_s = 1'b1; end
                end else if (timeout_s) begin
                    state_nxt = ST_HUNT;
                    err_s     = 1'b1;
                end else begin
                    state_nxt = ST_CHK;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    if (!rw_r && (len_r != 8'd0)) state_nxt = ST_STREAM;
                    else                          state_nxt = ST_HUNT;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_STREAM: begin
                if (wdata_valid_r && wdata_ready && wdata_last_r) state_nxt = ST_HUNT;
                else                                              state_nxt = ST_STREAM;
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

    // Frame fields, running XOR, buffer pointers, timeout and error bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r        <= 7'd0;
            rw_r          <= 1'b0;
            len_r         <= 8'd0;
            chk_r         <= 8'd0;
            cnt_r         <= 8'd0;
            rd_ptr_r      <= 8'd0;
            to_cnt_r      <= '0;
            cmd_valid_r   <= 1'b0;
            wdata_valid_r <= 1'b0;
            wdata_r       <= 8'd0;
            wdata_last_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            err_count_r   <= 8'd0;
        end else begin
            frame_err_r <= err_s;
            if (err_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end
            if (rx_rd_s || !in_frame_s) begin
                to_cnt_r <= '0;
            end else if (to_cnt_r != TO_LAST) begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end
            case (state_r)
                ST_HUNT: begin
                    cnt_r    <= 8'd0;
                    rd_ptr_r <= 8'd0;
                end
                ST_ADDR: begin
                    if (rx_rd_s) begin
                        addr_r <= rx_data[ADDR_MSB:ADDR_LSB];
                        rw_r   <= rx_data[ADDR_RW_BIT];
                        chk_r  <= rx_data;
                    end
                end
                ST_LEN: begin
                    if (rx_rd_s) begin
                        len_r <= rx_data;
                        chk_r <= chk_fold(chk_r, rx_data);
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_rd_s) begin
                        chk_r <= chk_fold(chk_r, rx_data);
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_CHK: begin
                    if (state_nxt == ST_ISSUE) begin
                        cmd_valid_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_r <= 1'b0;
                        if (state_nxt == ST_STREAM) begin
                            wdata_valid_r <= 1'b1;
                            wdata_r       <= buf_rdata_s;
                            wdata_last_r  <= (len_r == 8'd1);
                            rd_ptr_r      <= 8'd1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (wdata_valid_r && wdata_ready) begin
                        if (wdata_last_r) begin
                            wdata_valid_r <= 1'b0;
                            wdata_last_r  <= 1'b0;
                        end else begin
                            wdata_r      <= buf_rdata_s;
                            wdata_last_r <= (rd_ptr_r == (len_r - 8'd1));
                            rd_ptr_r     <= rd_ptr_r + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_rd       = rx_rd_s;
    assign cmd_valid   = cmd_valid_r;
    assign cmd_addr    = addr_r;
    assign cmd_rw      = rw_r;
    assign cmd_len     = len_r;
    assign wdata_valid = wdata_valid_r;
    assign wdata       = wdata_r;
    assign wdata_last  = wdata_last_r;
    assign frame_err   = frame_err_r;
    assign err_count   = err_count_r;

endmodule
